// File: rtl/piso_fifo_ser.sv
// piso_fifo_ser: parallel-in serial-out serialiser with an input FIFO.
//   Words enter through a ready/valid handshake into a FIFO_DEPTH-deep buffer.
//   Each word is shifted out one bit per clock and framed with sof/eof.
//   An optional idle gap of GAP_CYCLES clocks follows every word.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_in    parallel word, accepted when valid_in && ready_in
//   valid_in   data_in is valid
//   ready_in   FIFO has room for a word
//   data_out   serial bit (0 when valid_out is low)
//   valid_out  data_out carries a valid bit
//   sof/eof    first/last bit of a word
//   busy       shifting, in a gap, or FIFO non-empty
//   fifo_count words currently buffered
module piso_fifo_ser #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  output logic                              data_out,
  output logic                              valid_out,
  output logic                              sof,
  output logic                              eof,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(DATA_WIDTH - 2);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] shreg, shifted, head;
  logic [BW-1:0]         bit_cnt;
  logic [3:0]            gap_cnt;
  logic                  push, load;
  logic                  head_bit, next_bit;

  assign fifo_count = count;
  assign ready_in   = (count != FULL);
  assign push       = valid_in && ready_in;
  assign busy       = (state != IDLE) || (count != '0);
  assign head       = mem[rptr];

  assign shifted  = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[DATA_WIDTH-1:1]};
  assign head_bit = (MSB_FIRST != 0) ? head[DATA_WIDTH-1] : head[0];
  assign next_bit = (MSB_FIRST != 0) ? shifted[DATA_WIDTH-1] : shifted[0];

  // Load (= FIFO pop) happens from IDLE, at the end of the last bit when no
  // gap is configured, or on the edge that closes the gap.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = (count != '0);
      SHIFT:   load = (bit_cnt == LAST_BIT) && (GAP_CYCLES == 0) && (count != '0);
      GAP:     load = (gap_cnt == GAP_LAST) && (count != '0);
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serial outputs are registered alongside the state so they are valid
  // for the whole cycle following each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      valid_out <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      data_out  <= 1'b0;
    end else if (load) begin
      state     <= SHIFT;
      shreg     <= head;
      bit_cnt   <= '0;
      valid_out <= 1'b1;
      sof       <= 1'b1;
      eof       <= 1'b0;
      data_out  <= head_bit;
    end else begin
      case (state)
        IDLE: ;
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            state     <= (GAP_CYCLES != 0) ? GAP : IDLE;
            gap_cnt   <= '0;
            valid_out <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            data_out  <= 1'b0;
          end else begin
            shreg    <= shifted;
            bit_cnt  <= bit_cnt + 1'b1;
            sof      <= 1'b0;
            eof      <= (bit_cnt == PRE_LAST);
            data_out <= next_bit;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
